alu_ctrl_seq: RTL and testbench



---
 rtl/alu_ctrl_seq.sv | 205 ++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with multi-cycle mult/div sequencing.
// Build option: define MULDIV_EN to enable the BUSY/DONE mult/div sequencer and md_* outputs.
// Without MULDIV_EN, functs 0x18-0x1b decode as illegal and md_*/hilo_we are tied low.
module alu_ctrl_seq #(
  parameter int CTRL_W     = 4,
  parameter int FUNC_W     = 6,
  parameter int MD_LATENCY = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func_code,
  input  logic              stall_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic              md_start,
  output logic [1:0]        md_op,
  output logic              md_busy,
  output logic              hilo_we
);

  localparam int CNT_W = 8;

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ill_q, ill_d;
  logic              hold;
  logic              accept;
  logic [3:0]        dec_ctrl;
  logic              dec_ill;
`ifdef MULDIV_EN
  logic              dec_md;
`endif

  // A presented bundle that downstream refuses freezes every output register.
  assign hold   = valid_q && stall_in;
  assign accept = valid_in && ready_out;

  // Combinational decode of alu_op / funct into a 4-bit control code.
  always_comb begin
    dec_ctrl = 4'b0000;
    dec_ill  = 1'b0;
`ifdef MULDIV_EN
    dec_md   = 1'b0;
`endif
    case (alu_op)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b11: dec_ctrl = 4'b0000;
      default: begin
        case (func_code[5:0])
          6'h20, 6'h21: dec_ctrl = 4'b0010;
          6'h22, 6'h23: dec_ctrl = 4'b0110;
          6'h24:        dec_ctrl = 4'b0000;
          6'h25:        dec_ctrl = 4'b0001;
          6'h26:        dec_ctrl = 4'b0011;
          6'h27:        dec_ctrl = 4'b1100;
          6'h2a:        dec_ctrl = 4'b0111;
          6'h2b:        dec_ctrl = 4'b1000;
          6'h00:        dec_ctrl = 4'b1001;
          6'h02:        dec_ctrl = 4'b1010;
          6'h03:        dec_ctrl = 4'b1011;
`ifdef MULDIV_EN
          6'h18, 6'h19, 6'h1a, 6'h1b: dec_md = 1'b1;
`endif
          default:      dec_ill  = 1'b1;
        endcase
      end
    endcase
  end

`ifdef MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              md_start_q, md_start_d;
  logic              md_busy_q, md_busy_d;
  logic              hilo_q, hilo_d;
  logic [1:0]        md_op_q, md_op_d;

  assign ready_out = (state_q == IDLE) && !hold;

  // Next-state: single-cycle issue in IDLE, counted wait in BUSY, held result in DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    ill_d      = ill_q;
    md_start_d = 1'b0;
    md_op_d    = md_op_q;
    md_busy_d  = md_busy_q;
    hilo_d     = hilo_q;
    case (state_q)
      IDLE: begin
        if (!hold) begin
          valid_d = 1'b0;
          ctrl_d  = '0;
          ill_d   = 1'b0;
          hilo_d  = 1'b0;
          if (accept) begin
            if (dec_md) begin
              state_d    = BUSY;
              cnt_d      = CNT_W'(MD_LATENCY - 1);
              md_start_d = 1'b1;
              md_op_d    = func_code[1:0];
              md_busy_d  = 1'b1;
            end else begin
              valid_d = 1'b1;
              ctrl_d  = CTRL_W'(dec_ctrl);
              ill_d   = dec_ill;
            end
          end
        end
      end
      BUSY: begin
        // stall_in is deliberately ignored: the datapath runs a fixed latency.
        if (cnt_q == '0) begin
          state_d   = DONE;
          valid_d   = 1'b1;
          hilo_d    = 1'b1;
          ctrl_d    = '0;
          ill_d     = 1'b0;
          md_busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (!stall_in) begin
          state_d = IDLE;
          valid_d = 1'b0;
          hilo_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers; reset aborts any op in flight without a HI/LO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      md_start_q <= 1'b0;
      md_busy_q  <= 1'b0;
      hilo_q     <= 1'b0;
      md_op_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_start_q <= md_start_d;
      md_busy_q  <= md_busy_d;
      hilo_q     <= hilo_d;
      md_op_q    <= md_op_d;
    end
  end

  assign md_start = md_start_q;
  assign md_busy  = md_busy_q;
  assign md_op    = md_op_q;
  assign hilo_we  = hilo_q;
`else
  assign ready_out = !hold;

  // Next-state: register the decoded bundle on accept, drop valid after consumption.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    ill_d   = ill_q;
    if (!hold) begin
      valid_d = accept;
      ctrl_d  = accept ? CTRL_W'(dec_ctrl) : '0;
      ill_d   = accept && dec_ill;
    end
  end

  assign md_start = 1'b0;
  assign md_busy  = 1'b0;
  assign md_op    = 2'b00;
  assign hilo_we  = 1'b0;
`endif

  // Output bundle registers shared by both builds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      ill_q   <= ill_d;
    end
  end

  assign valid_out = valid_q;
  assign alu_ctrl  = ctrl_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed + randomized stimulus against a transaction-level model.
// Works in both builds; MULDIV_EN selects whether 0x18-0x1b are mult/div or illegal.
module tb_alu_ctrl_seq;
  localparam int L = 8;
`ifdef MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       valid_in = 1'b0, stall_in = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [5:0] func_code = 6'h00;
  logic       ready_out, valid_out, illegal, md_start, md_busy, hilo_we;
  logic [3:0] alu_ctrl;
  logic [1:0] md_op;

  alu_ctrl_seq #(.CTRL_W(4), .FUNC_W(6), .MD_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .alu_op(alu_op), .func_code(func_code), .stall_in(stall_in),
    .valid_out(valid_out), .alu_ctrl(alu_ctrl), .illegal(illegal),
    .md_start(md_start), .md_op(md_op), .md_busy(md_busy), .hilo_we(hilo_we)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: funct -> code lookup (-1 = illegal); mult/div range handled separately.
  int code_tbl[64];
  initial begin
    for (int i = 0; i < 64; i++) code_tbl[i] = -1;
    code_tbl[8'h20] = 2;  code_tbl[8'h21] = 2;
    code_tbl[8'h22] = 6;  code_tbl[8'h23] = 6;
    code_tbl[8'h24] = 0;  code_tbl[8'h25] = 1;
    code_tbl[8'h26] = 3;  code_tbl[8'h27] = 12;
    code_tbl[8'h2a] = 7;  code_tbl[8'h2b] = 8;
    code_tbl[8'h00] = 9;  code_tbl[8'h02] = 10; code_tbl[8'h03] = 11;
  end

  // Model state: presented bundle plus an in-flight mult/div tracked by completion edge.
  int         cyc = 0, done_edge = 0;
  bit         m_valid, m_ill, m_hilo, m_start, m_busy, m_done;
  logic [3:0] m_ctrl;
  logic [1:0] m_op;

  function automatic bit m_ready();
    return !m_busy && !m_done && !(m_valid && stall_in);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_ill = 0; m_hilo = 0; m_start = 0; m_busy = 0; m_done = 0;
    m_ctrl = 0; m_op = 0;
  endtask

  task automatic model_step();
    int f;
    cyc++;
    m_start = 0;
    if (m_busy) begin
      if (cyc == done_edge) begin
        m_busy = 0; m_done = 1; m_valid = 1; m_hilo = 1; m_ctrl = 0; m_ill = 0;
      end
    end else if (m_done) begin
      if (!stall_in) begin m_done = 0; m_valid = 0; m_hilo = 0; end
    end else if (!(m_valid && stall_in)) begin
      m_valid = 0; m_hilo = 0;
      if (valid_in) begin
        f = int'(func_code);
        m_valid = 1; m_ill = 0;
        case (alu_op)
          2'b00: m_ctrl = 4'd2;
          2'b01: m_ctrl = 4'd6;
          2'b11: m_ctrl = 4'd0;
          default: begin
            if (f >= 24 && f <= 27 && MD) begin
              m_valid = 0; m_busy = 1; m_start = 1; m_op = func_code[1:0];
              done_edge = cyc + L;
            end else if (code_tbl[f] < 0) begin
              m_ctrl = 0; m_ill = 1;
            end else begin
              m_ctrl = 4'(code_tbl[f]);
            end
          end
        endcase
      end
    end
  endtask

  task automatic check_outs();
    chk("valid_out", valid_out, m_valid);
    chk("hilo_we", hilo_we, m_hilo);
    chk("md_start", md_start, m_start);
    chk("md_busy", md_busy, m_busy);
    if (m_valid) begin
      chk("alu_ctrl", alu_ctrl, m_ctrl);
      chk("illegal", illegal, m_ill);
    end
    if (m_busy) chk("md_op", md_op, m_op);
    if (!MD) chk("md_op_tied", md_op, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_ctrl"}, alu_ctrl, 0);
    chk({tag, "_ill"}, illegal, 0);
    chk({tag, "_start"}, md_start, 0);
    chk({tag, "_op"}, md_op, 0);
    chk({tag, "_busy"}, md_busy, 0);
    chk({tag, "_hilo"}, hilo_we, 0);
  endtask

  bit last_acc;

  // One cycle: drive at negedge, check ready, step model at posedge, check at next negedge.
  task automatic tick(input bit v, input logic [1:0] op, input logic [5:0] f, input bit st);
    valid_in = v; alu_op = op; func_code = f; stall_in = st;
    #1;
    chk("ready_out", ready_out, m_ready());
    last_acc = v && m_ready();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic drain();
    for (int k = 0; k < L + 6 && (m_busy || m_done || m_valid); k++) tick(0, 0, 0, 0);
  endtask

  logic [5:0] fsel[8] = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h20, 6'h27, 6'h2b, 6'h03};

  initial begin
    bit v, st, pend;
    logic [1:0] op;
    logic [5:0] f;
    model_reset();
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fixed decodes back to back.
    tick(1, 2'b00, 6'h3f, 0);
    tick(1, 2'b01, 6'h3f, 0);
    tick(1, 2'b11, 6'h3f, 0);
    tick(0, 2'b00, 6'h00, 0);

    // Full funct sweep.
    for (int i = 0; i < 64; i++) begin
      tick(1, 2'b10, 6'(i), 0);
      drain();
    end

    // Single-cycle op held under a 3-cycle stall.
    tick(1, 2'b10, 6'h25, 0);
    for (int k = 0; k < 3; k++) tick(1, 2'b00, 6'h00, 1);
    tick(0, 2'b00, 6'h00, 0);
    tick(0, 2'b00, 6'h00, 0);

    // div with stalls in BUSY and DONE.
    tick(1, 2'b10, 6'h1a, 0);
    for (int k = 0; k < L + 8 && (m_busy || m_done); k++) tick(0, 0, 0, (k % 3) != 2);
    drain();

    // Reset in the middle of an op (counter at 4 in the mult/div build).
    tick(1, 2'b10, 6'h1a, 0);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    chk_all_zero("inreset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 2'b10, 6'h22, 0);
    for (int k = 0; k < L + 2; k++) tick(0, 0, 0, 0);

    // Randomized traffic; unaccepted requests are held stable.
    pend = 0; op = 0; f = 0;
    for (int n = 0; n < 600; n++) begin
      if (!pend) begin
        v  = ($urandom_range(0, 9) < 7);
        op = 2'($urandom_range(0, 3));
        f  = ($urandom_range(0, 1) == 1) ? fsel[$urandom_range(0, 7)] : 6'($urandom_range(0, 63));
      end
      st = ($urandom_range(0, 9) < 3);
      tick(v, op, f, st);
      pend = v && !last_acc;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
